// File: rtl/leb128_fetch_pkg.sv
// Shared constants for the LEB128 operand fetch stage: error codes, FSM states
// and the maximum encoded lengths for i32 and i64 immediates.
package leb128_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_SCAN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] LEB_OK       = 2'd0;
    localparam logic [1:0] LEB_MEMERR   = 2'd1;
    localparam logic [1:0] LEB_OVERLONG = 2'd2;
    localparam logic [1:0] LEB_WRAP     = 2'd3;

    localparam logic [3:0] MAX_LEN_NARROW = 4'd5;
    localparam logic [3:0] MAX_LEN_WIDE   = 4'd10;

endpackage

// File: rtl/leb128_fetch_acc.sv
// leb128_acc: per-byte shift/accumulate/length datapath for LEB128 decoding.
// Signed results (sign extension from the last 7-bit group) exist only when LEB128_SIGNED_EN is defined.
module leb128_acc
    import leb128_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [7:0]  byte_in,
    input  logic        wide,
    input  logic        signed_mode,
    output logic [3:0]  len,
    output logic [3:0]  len_next,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [6:0]  shift;
    logic [6:0]  shift_next;

    // Shifting by 64 or more yields zero, which discards groups past bit 63.
    always_comb begin
        acc_next   = acc | ({57'd0, byte_in[6:0]} << shift);
        shift_next = shift + 7'd7;
        len_next   = len + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc   <= 64'd0;
            shift <= 7'd0;
            len   <= 4'd0;
        end else if (step) begin
            acc   <= acc_next;
            shift <= shift_next;
            len   <= len_next;
        end
    end

`ifdef LEB128_SIGNED_EN
    logic [6:0]  sign_pos;
    logic        sign_bit;
    logic [31:0] lo;

    // The result reflects the byte currently presented, so it can be latched on the final byte.
    always_comb begin
        sign_pos = shift_next - 7'd1;
        sign_bit = acc_next[sign_pos[5:0]];
        lo       = acc_next[31:0];
        result   = wide ? acc_next : {32'd0, acc_next[31:0]};
        if (signed_mode) begin
            if (wide) begin
                if (shift_next < 7'd64 && sign_bit) begin
                    result = acc_next | (64'hFFFF_FFFF_FFFF_FFFF << shift_next);
                end
            end else begin
                if (shift_next < 7'd32 && sign_bit) begin
                    lo = lo | (32'hFFFF_FFFF << shift_next);
                end
                result = {{32{lo[31]}}, lo};
            end
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_mode;

    // The result reflects the byte currently presented, so it can be latched on the final byte.
    always_comb begin
        result = wide ? acc_next : {32'd0, acc_next[31:0]};
    end
`endif

endmodule

// File: rtl/leb128_fetch.sv
// leb128_fetch: reads one LEB128 immediate from genrom windows and returns value/length/err.
// Define LEB128_SIGNED_EN to honour req_signed; otherwise every decode is unsigned.
module leb128_fetch
    import leb128_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [MEM_DEPTH:0]            req_addr,
    input  logic                          req_wide,
    input  logic                          req_signed,
    output logic                          done,
    output logic [63:0]                   value,
    output logic [3:0]                    length,
    output logic [1:0]                    err,
    output logic [MEM_DEPTH:0]            mem_addr,
    output logic [MEM_EXTRA-1:0]          mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
    input  logic                          mem_error
);

    localparam int AW = MEM_DEPTH + 1;
    localparam int HW = AW - MEM_EXTRA;

    state_t              state;
    state_t              state_next;
    logic [HW-1:0]       base_hi;
    logic [MEM_EXTRA-1:0] ptr;
    logic                wide_q;
    logic                signed_q;
    logic                first_scan;
    logic [63:0]         value_q;
    logic [3:0]          length_q;
    logic [1:0]          err_q;
    logic [AW-1:0]       mem_addr_q;

    logic [7:0]          byte_cur;
    logic [3:0]          max_len;
    logic                acc_clear;
    logic                acc_step;
    logic                finish;
    logic                advance;
    logic [1:0]          finish_err;
    logic [3:0]          finish_len;
    logic [3:0]          acc_len;
    logic [3:0]          acc_len_next;
    logic [63:0]         acc_result;

    assign byte_cur  = mem_data[{ptr, 3'b000} +: 8];
    assign max_len   = wide_q ? MAX_LEN_WIDE : MAX_LEN_NARROW;
    assign req_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign value     = value_q;
    assign length    = length_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_extra = '1;

    leb128_acc u_acc (
        .clk         (clk),
        .reset       (reset),
        .clear       (acc_clear),
        .step        (acc_step),
        .byte_in     (byte_cur),
        .wide        (wide_q),
        .signed_mode (signed_q),
        .len         (acc_len),
        .len_next    (acc_len_next),
        .result      (acc_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A window's mem_error is only meaningful on its first SCAN cycle; after that the
    // window data is trusted until the last byte forces a refetch of the next base.
    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_step   = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        finish_err = LEB_OK;
        finish_len = acc_len;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_ADDR;
                    acc_clear  = 1'b1;
                end
            end
            ST_ADDR: state_next = ST_WAIT;
            ST_WAIT: state_next = ST_SCAN;
            ST_SCAN: begin
                if (first_scan && mem_error) begin
                    finish     = 1'b1;
                    finish_err = LEB_MEMERR;
                end else begin
                    acc_step   = 1'b1;
                    finish_len = acc_len_next;
                    if (!byte_cur[7]) begin
                        finish = 1'b1;
                    end else if (acc_len_next == max_len) begin
                        finish     = 1'b1;
                        finish_err = LEB_OVERLONG;
                    end else if (&ptr) begin
                        if (&base_hi) begin
                            finish     = 1'b1;
                            finish_err = LEB_WRAP;
                        end else begin
                            advance    = 1'b1;
                            state_next = ST_ADDR;
                        end
                    end
                end
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Windows are aligned, so the request address splits into a window base and a byte pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_hi    <= '0;
            ptr        <= '0;
            wide_q     <= 1'b0;
            signed_q   <= 1'b0;
            first_scan <= 1'b0;
            value_q    <= 64'd0;
            length_q   <= 4'd0;
            err_q      <= LEB_OK;
            mem_addr_q <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                base_hi  <= req_addr[AW-1:MEM_EXTRA];
                ptr      <= req_addr[MEM_EXTRA-1:0];
                wide_q   <= req_wide;
                signed_q <= req_signed;
            end
            if (state == ST_ADDR) begin
                mem_addr_q <= {base_hi, {MEM_EXTRA{1'b0}}};
                first_scan <= 1'b1;
            end
            if (state == ST_SCAN) begin
                first_scan <= 1'b0;
                if (acc_step) begin
                    ptr <= ptr + 1'b1;
                end
                if (advance) begin
                    base_hi <= base_hi + 1'b1;
                end
            end
            if (finish) begin
                value_q  <= (finish_err == LEB_OK) ? acc_result : 64'd0;
                length_q <= finish_len;
                err_q    <= finish_err;
            end
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Self-checking bench for leb128_fetch: directed cases then random decodes against
// a behavioural LEB128 model driving a byte-array genrom with one-cycle latency.
module tb_leb128_fetch;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   req_addr;
    logic         req_wide;
    logic         req_signed;
    logic         done;
    logic [63:0]  value;
    logic [3:0]   length;
    logic [1:0]   err;
    logic [6:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data;
    logic         mem_error;

    logic [7:0]   rom [128];
    int           err_win;
    int           checks;
    int           failures;

    logic [63:0]  obs_value;
    logic [3:0]   obs_len;
    logic [1:0]   obs_err;
    int           obs_lat;

    leb128_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wide   (req_wide),
        .req_signed (req_signed),
        .done       (done),
        .value      (value),
        .length     (length),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_extra  (mem_extra),
        .mem_data   (mem_data),
        .mem_error  (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Genrom model: registered window read with a bounds error on one chosen window base.
    always @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            mem_data[8*k +: 8] <= rom[(int'(mem_addr) + k) % 128];
        end
        mem_error <= (err_win >= 0) && (int'(mem_addr) == err_win);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic w, input logic s);
        bit got;
        @(negedge clk);
        checkOutput("ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_wide   = w;
        req_signed = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("ready_busy", req_ready, 1'b0);
        got     = 1'b0;
        obs_lat = 0;
        while (!got && obs_lat < 100) begin
            @(posedge clk);
            obs_lat++;
            #1;
            if (done) got = 1'b1;
        end
        checkOutput("timeout", got, 1'b1);
        obs_value = value;
        obs_len   = length;
        obs_err   = err;
        @(posedge clk);
        #1;
        checkOutput("done_pulse", done, 1'b0);
    endtask

    // LEB128 rules applied directly to the ROM byte array.
    function automatic void refDecode(input int start, input bit wide, input bit sgn, input int ew,
                                      output logic [63:0] v, output logic [3:0] n, output logic [1:0] e);
        longint unsigned acc;
        longint unsigned lo;
        int  a;
        int  s;
        int  cnt;
        int  maxn;
        bit  fin;
        bit  do_signed;
        logic [7:0] b;
        do_signed = sgn;
`ifndef LEB128_SIGNED_EN
        do_signed = 1'b0;
`endif
        acc  = 0;
        s    = 0;
        cnt  = 0;
        e    = 2'd0;
        a    = start;
        fin  = 1'b0;
        maxn = wide ? 10 : 5;
        while (!fin) begin
            if ((cnt == 0 || a % 16 == 0) && (a / 16) * 16 == ew) begin
                e   = 2'd1;
                fin = 1'b1;
            end else begin
                b = rom[a];
                if (s < 64) acc = acc | (64'(b[6:0]) << s);
                s   = s + 7;
                cnt = cnt + 1;
                if (!b[7]) fin = 1'b1;
                else if (cnt == maxn) begin e = 2'd2; fin = 1'b1; end
                else if (a == 127) begin e = 2'd3; fin = 1'b1; end
                else a = a + 1;
            end
        end
        n = 4'(cnt);
        if (e != 2'd0) begin
            v = 64'd0;
        end else if (wide) begin
            if (do_signed && s < 64 && ((acc >> (s - 1)) & 64'd1) != 0) acc = acc - (64'd1 << s);
            v = acc;
        end else begin
            lo = acc & 64'hFFFF_FFFF;
            if (do_signed) begin
                if (s < 32 && ((lo >> (s - 1)) & 64'd1) != 0) lo = (lo - (64'd1 << s)) & 64'hFFFF_FFFF;
                if (lo >= 64'h8000_0000) lo = lo + 64'hFFFF_FFFF_0000_0000;
            end
            v = lo;
        end
    endfunction

    initial begin
        logic [63:0] ev;
        logic [3:0]  en;
        logic [1:0]  ee;
        bit          seen_done;
        int          ra;
        bit          rw;
        bit          rs;

        checks     = 0;
        failures   = 0;
        err_win    = -1;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wide   = 1'b0;
        req_signed = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", req_ready, 1'b1);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_value", value, 64'd0);
        checkOutput("rst_length", length, 4'd0);
        checkOutput("rst_err", err, 2'd0);
        checkOutput("rst_mem_addr", mem_addr, 7'd0);
        checkOutput("mem_extra", mem_extra, 4'hF);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] single byte, latency");
        rom[17] = 8'h03;
        applyStimulus(7'd17, 1'b0, 1'b0);
        checkOutput("one_value", obs_value, 64'd3);
        checkOutput("one_len", obs_len, 4'd1);
        checkOutput("one_err", obs_err, 2'd0);
        checkOutput("one_latency", 64'(obs_lat), 64'd3);

        $display("[TB] three byte wide");
        rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26;
        applyStimulus(7'd0, 1'b1, 1'b0);
        checkOutput("three_value", obs_value, 64'd624485);
        checkOutput("three_len", obs_len, 4'd3);
        checkOutput("three_err", obs_err, 2'd0);

        $display("[TB] window crossing");
        rom[15] = 8'hE5; rom[16] = 8'h0E;
        applyStimulus(7'd15, 1'b0, 1'b0);
        checkOutput("cross_value", obs_value, 64'd1893);
        checkOutput("cross_len", obs_len, 4'd2);
        checkOutput("cross_base", mem_addr, 7'd16);

        $display("[TB] overlong narrow");
        for (int i = 0; i < 5; i++) rom[i] = 8'h80;
        rom[5] = 8'h00;
        applyStimulus(7'd0, 1'b0, 1'b0);
        checkOutput("ovl_err", obs_err, 2'd2);
        checkOutput("ovl_len", obs_len, 4'd5);
        checkOutput("ovl_value", obs_value, 64'd0);

        $display("[TB] signed narrow 0x7F");
        rom[0] = 8'h7F;
        applyStimulus(7'd0, 1'b0, 1'b1);
`ifdef LEB128_SIGNED_EN
        checkOutput("sgn_value", obs_value, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        checkOutput("sgn_value", obs_value, 64'h7F);
`endif
        checkOutput("sgn_len", obs_len, 4'd1);

        $display("[TB] ten byte wide max");
        for (int i = 48; i < 57; i++) rom[i] = 8'hFF;
        rom[57] = 8'h01;
        applyStimulus(7'd48, 1'b1, 1'b0);
        checkOutput("max_value", obs_value, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("max_len", obs_len, 4'd10);
        checkOutput("max_err", obs_err, 2'd0);
        rom[57] = 8'h81;
        applyStimulus(7'd48, 1'b1, 1'b0);
        checkOutput("ovl_wide_err", obs_err, 2'd2);
        checkOutput("ovl_wide_len", obs_len, 4'd10);

        $display("[TB] address wrap");
        rom[126] = 8'h80; rom[127] = 8'h80;
        applyStimulus(7'd126, 1'b1, 1'b0);
        checkOutput("wrap_err", obs_err, 2'd3);
        checkOutput("wrap_len", obs_len, 4'd2);
        checkOutput("wrap_value", obs_value, 64'd0);

        $display("[TB] mem_error first and second window");
        err_win = 64;
        rom[70] = 8'h05;
        applyStimulus(7'd70, 1'b0, 1'b0);
        checkOutput("merr1_err", obs_err, 2'd1);
        checkOutput("merr1_len", obs_len, 4'd0);
        rom[30] = 8'h81; rom[31] = 8'h82; rom[32] = 8'h03;
        err_win = 32;
        applyStimulus(7'd30, 1'b1, 1'b0);
        checkOutput("merr2_err", obs_err, 2'd1);
        checkOutput("merr2_len", obs_len, 4'd2);
        checkOutput("merr2_value", obs_value, 64'd0);
        err_win = -1;

        $display("[TB] reset during scan");
        rom[40] = 8'h80; rom[41] = 8'h80; rom[42] = 8'h01;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 7'd40; req_wide = 1'b1; req_signed = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready", req_ready, 1'b1);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_mem_addr", mem_addr, 7'd0);
        checkOutput("midrst_length", length, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checkOutput("midrst_no_done", seen_done, 1'b0);

        $display("[TB] random decodes");
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(0, 255));
            ra = $urandom_range(0, 127);
            rw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: err_win = (ra / 16) * 16;
                1: err_win = ((ra / 16 + 1) % 8) * 16;
                default: err_win = -1;
            endcase
            refDecode(ra, rw, rs, err_win, ev, en, ee);
            applyStimulus(7'(ra), rw, rs);
            checkOutput("rnd_value", obs_value, ev);
            checkOutput("rnd_len", obs_len, 64'(en));
            checkOutput("rnd_err", obs_err, 64'(ee));
        end
        err_win = -1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
